alu: RTL and testbench
======================

// Module: alu
// PURPOSE
//  Registered integer ALU: one result per clk_fake cycle from a 6-bit opcode and two operands.
//  Execution-stage datapath element of the Synergistic Processing Unit.
//  Fed by the decode/operand-fetch stage; its output goes to writeback.
// PARAMETERS
//  dataWidth  8  operand/result width in bits (>=4, power of 2); SW = $clog2(dataWidth)
// PORTS
//  clk_fake  in   1          sole clock; all state updates on posedge
//  rst_n     in   1          asynchronous, active-low reset
//  opCode    in   6          operation select (map below)
//  inA       in   dataWidth  operand A
//  inB       in   dataWidth  operand B
//  dataOut   out  dataWidth  registered result
// BEHAVIOUR
//  - Interface: one clock (clk_fake); reset rst_n is asynchronous, active-low.
//  - rst_n=0: dataOut=0 immediately, regardless of clock; held 0 while low.
//  - First posedge after rst_n rises loads a normal result.
//  - Latency 1: opCode/inA/inB sampled at posedge N; result on dataOut after posedge N.
//  - dataOut holds until next posedge. No handshake: every opcode except NOP updates every cycle.
//  - Width: wrap mod 2^dataWidth; no carry/overflow outputs.
//  - Signed ops use two's complement; shift amount s = inB[SW-1:0] (upper bits ignored).
//  - Opcode map (R = next dataOut):
//     0 PASSA R=A | 1 PASSB R=B | 2 NOTA R=~A | 3 AND | 4 OR | 5 XOR | 6 NAND | 7 NOR | 8 XNOR
//     16 INC A+1 | 17 DEC A-1 | 18 NEG -A | 19 ADD A+B | 20 SUB A-B
//     21 ABSDIFF |A-B| (unsigned) | 22 AVG (A+B+1)>>1, computed in dataWidth+1 bits
//     23 MULLO low dataWidth bits of unsigned A*B
//     32 SHL A<<s | 33 SHR logical A>>s | 34 SRA arithmetic A>>>s | 35 ROTL A by s | 36 ROTR A by s
//     40 CEQ R=all-ones if A==B else 0 | 41 CGT signed A>B -> all-ones/0
//     42 CGTU unsigned A>B -> all-ones/0 | 43 MINU | 44 MAXU
//     63 NOP: dataOut holds its previous value
//     all other opcodes: R=0
//  - Boundaries:
//     s=0 -> shifts/rotates return A unchanged.
//     SRA on negative A fills with ones.
//     NEG of most-negative value returns itself; SUB underflow wraps.
//     AVG of all-ones+all-ones returns all-ones (no lost carry).
//     NOP straight after reset keeps 0.
//  - Async reset asserted mid-stream overrides any pending result.
//  - Outputs are pure flops; combinational result path must settle within one cycle.
// TESTING
//  Bench drives inputs on negedge clk_fake and checks after posedge; dataWidth=8.
//  - Reset, then op63, A=12, B=10 -> dataOut stays 0.
//  - op4 OR -> 14 (0x0E); op20 SUB -> 2; then op63 -> dataOut holds 2.
//  - op19 A=200, B=100 -> 44 (wrap).
//  - op23 A=12, B=10 -> 120.
//  - op34 SRA A=0x90, B=0x0B (s=3) -> 0xF2.
//  - op32 SHL A=12, B=10 (s=2) -> 48.
//  - op41 A=0x80, B=0x01 -> 0x00; op42 same operands -> 0xFF.
//  - Undefined op 9 -> 0.
//  - Pull rst_n low between clock edges -> dataOut=0 before next posedge; release -> next op loads normally.

Source files
------------

// File: rtl/alu.sv
// Registered integer ALU: a 6-bit opcode selects one result per clk_fake cycle.
// The result flop clears asynchronously and holds its value on NOP (63).
module alu #(
   parameter int dataWidth = 8
) (
   input  logic                 clk_fake,
   input  logic                 rst_n,
   input  logic [5:0]           opCode,
   input  logic [dataWidth-1:0] inA,
   input  logic [dataWidth-1:0] inB,
   output logic [dataWidth-1:0] dataOut
);

   localparam int SW = $clog2(dataWidth);
   localparam logic [SW:0] L_WIDTH = (SW+1)'(dataWidth);

   logic [dataWidth-1:0] r_data_out;
   logic [dataWidth-1:0] w_next;
   logic [SW-1:0]        w_s;
   logic [SW:0]          w_inv;
   logic [dataWidth:0]   w_avg_sum;
   logic [dataWidth-1:0] w_ones;
   logic [dataWidth-1:0] w_zero;

   assign w_s       = inB[SW-1:0];
   // Complement shift amount for rotates; equals dataWidth when s=0, so the wrap term vanishes.
   assign w_inv     = L_WIDTH - {1'b0, w_s};
   assign w_avg_sum = {1'b0, inA} + {1'b0, inB} + {{dataWidth{1'b0}}, 1'b1};
   assign w_ones    = {dataWidth{1'b1}};
   assign w_zero    = {dataWidth{1'b0}};

   // Next-result selection from the opcode.
   always_comb begin
      w_next = w_zero;
      case (opCode)
         6'd0:  w_next = inA;
         6'd1:  w_next = inB;
         6'd2:  w_next = ~inA;
         6'd3:  w_next = inA & inB;
         6'd4:  w_next = inA | inB;
         6'd5:  w_next = inA ^ inB;
         6'd6:  w_next = ~(inA & inB);
         6'd7:  w_next = ~(inA | inB);
         6'd8:  w_next = ~(inA ^ inB);
         6'd16: w_next = inA + {{(dataWidth-1){1'b0}}, 1'b1};
         6'd17: w_next = inA - {{(dataWidth-1){1'b0}}, 1'b1};
         6'd18: w_next = w_zero - inA;
         6'd19: w_next = inA + inB;
         6'd20: w_next = inA - inB;
         6'd21: begin
            if (inA >= inB) begin
               w_next = inA - inB;
            end else begin
               w_next = inB - inA;
            end
         end
         6'd22: w_next = w_avg_sum[dataWidth:1];
         6'd23: w_next = inA * inB;
         6'd32: w_next = inA << w_s;
         6'd33: w_next = inA >> w_s;
         6'd34: w_next = $signed(inA) >>> w_s;
         6'd35: w_next = (inA << w_s) | (inA >> w_inv);
         6'd36: w_next = (inA >> w_s) | (inA << w_inv);
         6'd40: w_next = (inA == inB) ? w_ones : w_zero;
         6'd41: w_next = ($signed(inA) > $signed(inB)) ? w_ones : w_zero;
         6'd42: w_next = (inA > inB) ? w_ones : w_zero;
         6'd43: w_next = (inA < inB) ? inA : inB;
         6'd44: w_next = (inA > inB) ? inA : inB;
         6'd63: w_next = r_data_out;
         default: w_next = w_zero;
      endcase
   end

   // Result register with asynchronous clear.
   always_ff @(posedge clk_fake or negedge rst_n) begin
      if (!rst_n) begin
         r_data_out <= {dataWidth{1'b0}};
      end else begin
         r_data_out <= w_next;
      end
   end

   assign dataOut = r_data_out;

endmodule

// File: tb/tb_alu.sv
// Randomized self-checking bench for alu (dataWidth=8) against an integer-arithmetic model,
// plus hand-computed literal expectations and an asynchronous reset in mid-stream.
module tb_alu;

   logic       clk_fake;
   logic       rst_n;
   logic [5:0] opCode;
   logic [7:0] inA;
   logic [7:0] inB;
   logic [7:0] dataOut;

   int   n_pass  = 0;
   int   n_total = 0;
   bit   chk_en  = 1'b0;
   int   exp_q   = 0;

   alu #(.dataWidth(8)) dut (
      .clk_fake (clk_fake),
      .rst_n    (rst_n),
      .opCode   (opCode),
      .inA      (inA),
      .inB      (inB),
      .dataOut  (dataOut)
   );

   initial begin
      clk_fake = 1'b0;
      forever #5 clk_fake = ~clk_fake;
   end

   task automatic check(input string name, input logic [7:0] act, input int expv);
      n_total++;
      if (act !== 8'(expv)) begin
         $display("FAIL %s: got 0x%02h expected 0x%02h (t=%0t op=%0d A=0x%02h B=0x%02h)",
                  name, act, 8'(expv), $time, opCode, inA, inB);
      end else begin
         n_pass++;
      end
   endtask

   function automatic int sgn(input int v);
      return (v >= 128) ? v - 256 : v;
   endfunction

   // Reference model in plain integer arithmetic modulo 256.
   function automatic int model(input int op, input int a, input int b, input int prev);
      int s;
      s = b % 8;
      case (op)
         0:  return a;
         1:  return b;
         2:  return 255 - a;
         3:  return a & b;
         4:  return a | b;
         5:  return a ^ b;
         6:  return 255 - (a & b);
         7:  return 255 - (a | b);
         8:  return 255 - (a ^ b);
         16: return (a + 1) % 256;
         17: return (a + 255) % 256;
         18: return (256 - a) % 256;
         19: return (a + b) % 256;
         20: return (a - b + 256) % 256;
         21: return (a > b) ? a - b : b - a;
         22: return (a + b + 1) / 2;
         23: return (a * b) % 256;
         32: return (a * (1 << s)) % 256;
         33: return a / (1 << s);
         34: return (sgn(a) >= 0) ? a / (1 << s)
                                  : (256 - ((-sgn(a) + (1 << s) - 1) / (1 << s))) % 256;
         35: return ((a * (1 << s)) % 256) + a / (1 << (8 - s));
         36: return a / (1 << s) + ((a * (1 << (8 - s))) % 256);
         40: return (a == b) ? 255 : 0;
         41: return (sgn(a) > sgn(b)) ? 255 : 0;
         42: return (a > b) ? 255 : 0;
         43: return (a < b) ? a : b;
         44: return (a > b) ? a : b;
         63: return prev;
         default: return 0;
      endcase
   endfunction

   // Model update at each posedge, compared 1 time unit later.
   always @(posedge clk_fake) begin
      if (!rst_n) begin
         exp_q = 0;
      end else begin
         exp_q = model(int'(opCode), int'(inA), int'(inB), exp_q);
      end
      #1;
      if (chk_en) check("model", dataOut, exp_q);
   end

   always @(negedge rst_n) exp_q = 0;

   task automatic step(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                       input string name, input int lit);
      @(negedge clk_fake);
      opCode = op; inA = a; inB = b;
      @(posedge clk_fake);
      #2;
      check(name, dataOut, lit);
   endtask

   int ops[29] = '{0,1,2,3,4,5,6,7,8,16,17,18,19,20,21,22,23,32,33,34,35,36,40,41,42,43,44,63,9};

   initial begin
      rst_n = 1'b0; opCode = 6'd0; inA = 8'd0; inB = 8'd0;
      repeat (3) @(posedge clk_fake);
      #2;
      check("reset_value", dataOut, 0);
      @(negedge clk_fake);
      rst_n = 1'b1;
      chk_en = 1'b1;

      step(6'd63, 8'd12,  8'd10,  "nop_after_reset", 0);
      step(6'd4,  8'd12,  8'd10,  "or",       8'h0E);
      step(6'd20, 8'd12,  8'd10,  "sub",      2);
      step(6'd63, 8'd12,  8'd10,  "nop_hold", 2);
      step(6'd19, 8'd200, 8'd100, "add_wrap", 44);
      step(6'd23, 8'd12,  8'd10,  "mullo",    120);
      step(6'd34, 8'h90,  8'h0B,  "sra_neg",  8'hF2);
      step(6'd32, 8'd12,  8'd10,  "shl",      48);
      step(6'd41, 8'h80,  8'h01,  "cgt",      8'h00);
      step(6'd42, 8'h80,  8'h01,  "cgtu",     8'hFF);
      step(6'd9,  8'h55,  8'h33,  "undef_op", 0);
      step(6'd22, 8'hFF,  8'hFF,  "avg_max",  8'hFF);
      step(6'd18, 8'h80,  8'h00,  "neg_min",  8'h80);
      step(6'd20, 8'd3,   8'd5,   "sub_under", 8'hFE);
      step(6'd33, 8'hA5,  8'h08,  "shr_s0",   8'hA5);
      step(6'd35, 8'h81,  8'h01,  "rotl",     8'h03);
      step(6'd36, 8'h81,  8'h01,  "rotr",     8'hC0);
      step(6'd21, 8'd5,   8'd200, "absdiff",  195);
      step(6'd19, 8'd1,   8'd2,   "pre_reset", 3);

      #1 rst_n = 1'b0;
      #1 check("async_reset", dataOut, 0);
      @(negedge clk_fake);
      rst_n = 1'b1; opCode = 6'd0; inA = 8'h5A; inB = 8'h00;
      @(posedge clk_fake);
      #2 check("post_reset_load", dataOut, 8'h5A);

      for (int i = 0; i < 2000; i++) begin
         @(negedge clk_fake);
         if ($urandom_range(0, 7) == 0) begin
            opCode = 6'($urandom_range(0, 63));
         end else begin
            opCode = 6'(ops[$urandom_range(0, 28)]);
         end
         inA = 8'($urandom);
         inB = 8'($urandom);
      end
      @(posedge clk_fake);
      #3;
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
